// File: rtl/pcie_dllp_tx_sched_pkg.sv
// Shared DLLP type codes, body layouts and round-robin indices for the
// DLLP transmit scheduler.
package pcie_dllp_tx_sched_pkg;

  localparam logic [7:0] DLLP_ACK       = 8'h00;
  localparam logic [7:0] DLLP_NAK       = 8'h10;
  localparam logic [7:0] DLLP_UPDFC_P   = 8'h80;
  localparam logic [7:0] DLLP_UPDFC_NP  = 8'h90;
  localparam logic [7:0] DLLP_UPDFC_CPL = 8'hA0;

  localparam logic [1:0] RR_P   = 2'd0;
  localparam logic [1:0] RR_NP  = 2'd1;
  localparam logic [1:0] RR_CPL = 2'd2;

  typedef struct packed {
    logic [7:0]  dllp_type;
    logic [1:0]  hdr_scale;
    logic [7:0]  hdr_fc;
    logic [1:0]  data_scale;
    logic [11:0] data_fc;
  } updatefc_body_t;

  typedef struct packed {
    logic [7:0]  dllp_type;
    logic [11:0] rsvd;
    logic [11:0] seq;
  } acknak_body_t;

endpackage

// File: rtl/pcie_dllp_tx_sched_if.sv
// Valid/ready bus carrying 32-bit DLLP bodies from the scheduler to the framer.
interface pcie_dllp_tx_sched_if;
  logic        dllp_valid;
  logic [31:0] dllp_data;
  logic        dllp_ready;

  modport master (output dllp_valid, output dllp_data, input dllp_ready);
  modport slave  (input dllp_valid, input dllp_data, output dllp_ready);
endinterface

// File: rtl/pcie_dllp_tx_sched_rr_arb.sv
// Three-way round-robin arbiter over pending UpdateFC types; the pointer
// names the type with highest priority and moves past each served grant.
module dllp_fc_rr_arb
  import pcie_dllp_tx_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic       advance,
  output logic [2:0] grant
);

  logic [1:0] ptr_q, ptr_d;

  always_comb begin
    grant = 3'b000;
    case (ptr_q)
      RR_NP: begin
        if      (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
      end
      RR_CPL: begin
        if      (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
      end
      default: begin
        if      (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
      end
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      case (grant)
        3'b001:  ptr_d = RR_NP;
        3'b010:  ptr_d = RR_CPL;
        3'b100:  ptr_d = RR_P;
        default: ptr_d = ptr_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= RR_P;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/pcie_dllp_tx_sched.sv
// DLLP transmit scheduler: collects Ack/Nak/UpdateFC requests, arbitrates
// Nak > Ack > UpdateFC, and feeds one DLLP body per slot to the framer.
module pcie_dllp_tx_sched
  import pcie_dllp_tx_sched_pkg::*;
#(
  parameter int         UPDFC_INTERVAL = 7500,
  parameter logic [1:0] HDR_SCALE      = 2'b00,
  parameter logic [1:0] DATA_SCALE     = 2'b00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dl_active,
  input  logic        ack_req,
  input  logic        nak_req,
  input  logic [11:0] acknak_seq,
  input  logic [2:0]  fc_upd_req,
  input  logic [7:0]  hdr_fc_p,
  input  logic [7:0]  hdr_fc_np,
  input  logic [7:0]  hdr_fc_cpl,
  input  logic [11:0] data_fc_p,
  input  logic [11:0] data_fc_np,
  input  logic [11:0] data_fc_cpl,
  pcie_dllp_tx_sched_if.master dllp
);

  localparam int            TW         = $clog2(UPDFC_INTERVAL);
  localparam logic [TW-1:0] TIMER_LAST = TW'(UPDFC_INTERVAL - 1);

  logic          ack_pend_q, ack_pend_d;
  logic          nak_pend_q, nak_pend_d;
  logic [11:0]   seq_q, seq_d;
  logic [2:0]    fc_pend_q, fc_pend_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          dllp_valid_q, dllp_valid_d;
  logic [31:0]   dllp_data_q, dllp_data_d;

  logic           timer_exp, ack_new, nak_eff, ack_eff;
  logic           load, sel_nak, sel_ack, sel_fc, fc_adv;
  logic [2:0]     fc_req, fc_eff, fc_grant;
  updatefc_body_t fc_body;
  acknak_body_t   an_body;

  dllp_fc_rr_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (fc_eff),
    .advance (fc_adv),
    .grant   (fc_grant)
  );

  // Requests arriving this cycle are visible to arbitration so an idle
  // output loads them on the very next edge.
  always_comb begin
    timer_exp = dl_active && (timer_q == TIMER_LAST);
    fc_req    = fc_upd_req | {3{timer_exp}};
    ack_new   = ack_req && !nak_req && !nak_pend_q;
    nak_eff   = nak_pend_q || nak_req;
    ack_eff   = !nak_req && (ack_pend_q || ack_new);
    fc_eff    = fc_pend_q | fc_req;
    sel_nak   = nak_eff;
    sel_ack   = !nak_eff && ack_eff;
    sel_fc    = !nak_eff && !ack_eff && (|fc_eff);
    load      = dl_active && (!dllp_valid_q || dllp.dllp_ready)
                && (nak_eff || ack_eff || (|fc_eff));
    fc_adv    = load && sel_fc;
  end

  // A type already pending is sent with its stored sequence number; a
  // fresh pulse is sent with the sequence number on the input.
  always_comb begin
    an_body.dllp_type = sel_nak ? DLLP_NAK : DLLP_ACK;
    an_body.rsvd      = 12'h000;
    an_body.seq       = (sel_nak ? nak_pend_q : ack_pend_q) ? seq_q : acknak_seq;

    fc_body.dllp_type  = DLLP_UPDFC_P;
    fc_body.hdr_scale  = HDR_SCALE;
    fc_body.hdr_fc     = hdr_fc_p;
    fc_body.data_scale = DATA_SCALE;
    fc_body.data_fc    = data_fc_p;
    if (fc_grant[1]) begin
      fc_body.dllp_type = DLLP_UPDFC_NP;
      fc_body.hdr_fc    = hdr_fc_np;
      fc_body.data_fc   = data_fc_np;
    end else if (fc_grant[2]) begin
      fc_body.dllp_type = DLLP_UPDFC_CPL;
      fc_body.hdr_fc    = hdr_fc_cpl;
      fc_body.data_fc   = data_fc_cpl;
    end
  end

  // A loaded type stays pending only if it was already pending and a new
  // request for it arrived in the same cycle.
  always_comb begin
    seq_d        = (ack_req || nak_req) ? acknak_seq : seq_q;
    nak_pend_d   = (load && sel_nak) ? (nak_pend_q && nak_req) : nak_eff;
    ack_pend_d   = (load && sel_ack) ? (ack_pend_q && ack_new) : ack_eff;
    fc_pend_d    = fc_eff & ~(fc_adv ? (fc_grant & ~(fc_pend_q & fc_req)) : 3'b000);
    timer_d      = (timer_q == TIMER_LAST) ? '0 : timer_q + 1'b1;
    dllp_valid_d = load ? 1'b1 : (dllp.dllp_ready ? 1'b0 : dllp_valid_q);
    dllp_data_d  = load ? (sel_fc ? 32'(fc_body) : 32'(an_body)) : dllp_data_q;
    if (!dl_active) begin
      seq_d        = seq_q;
      nak_pend_d   = 1'b0;
      ack_pend_d   = 1'b0;
      fc_pend_d    = 3'b000;
      timer_d      = '0;
      dllp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_pend_q   <= 1'b0;
      nak_pend_q   <= 1'b0;
      seq_q        <= 12'h000;
      fc_pend_q    <= 3'b000;
      timer_q      <= '0;
      dllp_valid_q <= 1'b0;
      dllp_data_q  <= 32'h0;
    end else begin
      ack_pend_q   <= ack_pend_d;
      nak_pend_q   <= nak_pend_d;
      seq_q        <= seq_d;
      fc_pend_q    <= fc_pend_d;
      timer_q      <= timer_d;
      dllp_valid_q <= dllp_valid_d;
      dllp_data_q  <= dllp_data_d;
    end
  end

  assign dllp.dllp_valid = dllp_valid_q;
  assign dllp.dllp_data  = dllp_data_q;

endmodule
